// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the write-back stage: instruction codes, status codes,
// register ids and the processor status FSM state type.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] R_RSP  = 4'h4;
  localparam logic [3:0] R_NONE = 4'hF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    ERROR = 2'd2
  } state_t;

endpackage

// File: rtl/writeback_regfile_wb_dst_sel.sv
// Destination register selection for the retiring instruction (dstE / dstM).
module wb_dst_sel
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic       cnd,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  output logic [3:0] dst_e,
  output logic [3:0] dst_m
);

  always_comb begin
    dst_e = R_NONE;
    case (icode)
      I_RRMOVQ:                        dst_e = cnd ? rB : R_NONE;
      I_IRMOVQ, I_OPQ:                 dst_e = rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:  dst_e = R_RSP;
      default:                         dst_e = R_NONE;
    endcase
  end

  always_comb begin
    dst_m = R_NONE;
    if (icode == I_MRMOVQ || icode == I_POPQ) dst_m = rA;
  end

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage with architectural register file, status FSM and retire counter.
// Optional macro REGFILE_BYPASS_EN forwards the value being committed to the decode read ports.
module writeback_regfile
  import y86_pkg::*;
#(
  parameter int NREG  = 15,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  input  logic [3:0]       icode,
  input  logic             cnd,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic [63:0]      valE,
  input  logic [63:0]      valM,
  input  logic [2:0]       stat_in,
  input  logic [3:0]       srcA,
  input  logic [3:0]       srcB,
  output logic [63:0]      rdA,
  output logic [63:0]      rdB,
  input  logic [3:0]       dbg_sel,
  output logic [63:0]      dbg_data,
  output logic [2:0]       cpu_stat,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  logic [63:0] regs [NREG];
  logic [3:0]  dst_e;
  logic [3:0]  dst_m;
  state_t      state;
  logic        commit;

  wb_dst_sel u_dst_sel (
    .icode (icode),
    .cnd   (cnd),
    .rA    (rA),
    .rB    (rB),
    .dst_e (dst_e),
    .dst_m (dst_m)
  );

  // A halting or faulting instruction never commits, even on the cycle it arrives.
  assign commit = wb_valid && (state == RUN) && (stat_in == S_AOK);

  // dstM is written after dstE so that popq %rsp keeps the memory value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NREG; i++) begin
        if (dst_m == 4'(i))      regs[i] <= valM;
        else if (dst_e == 4'(i)) regs[i] <= valE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      cpu_stat <= S_AOK;
      halted   <= 1'b0;
    end else if (wb_valid && state == RUN) begin
      case (stat_in)
        S_AOK: ;
        S_HLT: begin
          state    <= HALT;
          cpu_stat <= S_HLT;
          halted   <= 1'b1;
        end
        S_ADR: begin
          state    <= ERROR;
          cpu_stat <= S_ADR;
          halted   <= 1'b1;
        end
        default: begin
          state    <= ERROR;
          cpu_stat <= S_INS;
          halted   <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (commit) instret <= instret + 1'b1;
  end

  always_comb begin
    rdA = (srcA == R_NONE || int'(srcA) >= NREG) ? 64'd0 : regs[srcA];
`ifdef REGFILE_BYPASS_EN
    if (commit && srcA != R_NONE) begin
      if (srcA == dst_m)      rdA = valM;
      else if (srcA == dst_e) rdA = valE;
    end
`endif
  end

  always_comb begin
    rdB = (srcB == R_NONE || int'(srcB) >= NREG) ? 64'd0 : regs[srcB];
`ifdef REGFILE_BYPASS_EN
    if (commit && srcB != R_NONE) begin
      if (srcB == dst_m)      rdB = valM;
      else if (srcB == dst_e) rdB = valE;
    end
`endif
  end

  assign dbg_data = (dbg_sel == R_NONE || int'(dbg_sel) >= NREG) ? 64'd0 : regs[dbg_sel];

endmodule
